mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  Memory-access stage of the 5-stage RV32I pipeline. Sits between EX and WB.
//  Issues load/store requests to data memory and formats load data (byte/half/word, sign/zero).
//  Registers the MEM/WB boundary: alu_or_ia4, data, is_load, rd, wb_enable consumed by WB.
//  Stalls upstream while a memory access is outstanding; times out on a hung bus.
// PARAMETERS
//  TIMEOUT  16  max cycles dmem_req may wait for dmem_ready before bus error (>=2)
// PORTS
//  clk            in   1   single clock, rising edge
//  rst            in   1   asynchronous, active-high reset
//  in_valid       in   1   EX presents a valid instruction
//  in_ready       out  1   stage can accept (transfer = in_valid & in_ready)
//  wb_enable_in   in   1   instruction writes rd
//  alu_or_ia4_in  in   32  ALU result (address for ld/st) or PC+4 for jumps
//  store_data     in   32  rs2 value for stores
//  is_load_in     in   1   load instruction
//  is_store       in   1   store instruction
//  funct3         in   3   access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
//  rd_in          in   5   destination register
//  dmem_req       out  1   memory request, held until dmem_ready
//  dmem_we        out  1   1=store, 0=load
//  dmem_addr      out  32  word-aligned address ({addr[31:2],2'b00})
//  dmem_wdata     out  32  store data, lane-replicated
//  dmem_be        out  4   byte enables (stores); 4'b1111 for loads
//  dmem_ready     in   1   memory completes request this cycle
//  dmem_rdata     in   32  load word, valid when dmem_ready
//  wb_enable      out  1   to WB: write rd (0 = bubble)
//  alu_or_ia4     out  32  to WB
//  data           out  32  to WB: formatted load data
//  is_load        out  1   to WB: mux select
//  rd             out  5   to WB
//  misalign_err   out  1   1-cycle pulse: misaligned or illegal funct3 access
//  bus_err        out  1   1-cycle pulse: TIMEOUT expired
// BEHAVIOUR
//  Reset: state IDLE, all outputs 0, timeout counter 0; an in-flight request is dropped.
//  FSM IDLE: in_ready=1. Each cycle MEM/WB regs load: non-mem valid op -> pass fields,
//   data=0, latency 1; no valid -> bubble (wb_enable=0, others hold previous value).
//  IDLE + valid ld/st, aligned: capture addr/be/wdata/rd/funct3 -> BUSY; output bubble.
//  IDLE + valid ld/st, misaligned (h: a[0]=1; w: a[1:0]!=0) or funct3 in {011,110,111}:
//   misalign_err=1 next cycle, no request, bubble, stay IDLE.
//  BUSY: in_ready=0, dmem_req=1, addr/we/be/wdata stable; outputs hold bubble.
//   dmem_ready=1 -> regs load (load: data=formatted rdata, is_load=1), -> IDLE; counter=0.
//   counter==TIMEOUT-1 without ready -> bus_err pulse, bubble, dmem_req drops, -> IDLE.
//  Memory op latency = 1 (accept) + cycles to dmem_ready; result visible cycle after ready.
//  Load format, a=addr[1:0]: lb/lbu select byte a, lh/lhu halfword a[1]; sign/zero-extend to 32.
//  Store: sb be=4'b0001<<a, wdata={4{byte}}; sh be=4'b0011<<a, wdata={2{half}}; sw be=4'hF.
//  is_load && is_store both set: treated as load. Stores force wb_enable=0 regardless of input.
//  dmem_ready outside BUSY is ignored.
// TESTING
//  lw a=0x100, ready after 3 cycles, rdata=0xDEADBEEF -> in_ready low 4 cycles, data=0xDEADBEEF, rd set.
//  lb a=0x103 rdata=0x80112233 -> data=0xFFFFFF80; lbu same -> 0x00000080; lhu a=0x102 -> 0x00008011.
//  sb a=0x21 data=0x000000AB -> dmem_be=4'b0010, dmem_wdata=0xABABABAB, dmem_we=1, wb_enable=0.
//  lw a=0x102 -> misalign_err pulse, dmem_req never high, wb_enable=0, in_ready stays 1.
//  load with dmem_ready never high -> bus_err pulse after 16 cycles, dmem_req drops, IDLE.
//  rst asserted mid-BUSY -> dmem_req=0 and all outputs 0 immediately; next op proceeds normally.

Source files
------------

// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - data-memory request/response bus between the MEM stage and data memory
interface mem_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_ready, dmem_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - RV32I memory-access stage: dmem request FSM, load formatting, MEM/WB registers
module mem_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        wb_enable_in,
    input  logic [31:0] alu_or_ia4_in,
    input  logic [31:0] store_data,
    input  logic        is_load_in,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd_in,
    mem_stage_if.master dmem,
    output logic        wb_enable,
    output logic [31:0] alu_or_ia4,
    output logic [31:0] data,
    output logic        is_load,
    output logic [4:0]  rd,
    output logic        misalign_err,
    output logic        bus_err
);
    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    typedef enum logic {IDLE, BUSY} state_t;
    state_t state, state_next;

    logic [CW-1:0] cnt;
    logic [31:0]   cap_alu;
    logic [4:0]    cap_rd;
    logic [2:0]    cap_f3;
    logic          cap_load, cap_wb;
    logic          req_q, we_q;
    logic [31:0]   addr_q, wdata_q;
    logic [3:0]    be_q;

    logic          is_mem, bad_f3, misalign, start_ok, start_bad, done, timeout_hit;
    logic [1:0]    a_in;
    logic [3:0]    be_st;
    logic [31:0]   wdata_st, rshift, fmt;
    logic [15:0]   half;

    assign a_in        = alu_or_ia4_in[1:0];
    assign is_mem      = is_load_in | is_store;
    assign bad_f3      = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
    assign misalign    = (funct3[1:0] == 2'b01 && a_in[0]) || (funct3[1:0] == 2'b10 && a_in != 2'b00);
    assign start_ok    = (state == IDLE) && in_valid && is_mem && !bad_f3 && !misalign;
    assign start_bad   = (state == IDLE) && in_valid && is_mem && (bad_f3 || misalign);
    assign done        = (state == BUSY) && dmem.dmem_ready;
    assign timeout_hit = (state == BUSY) && !dmem.dmem_ready && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start_ok) state_next = BUSY;
            BUSY: if (done || timeout_hit) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // in_ready is gated by rst so every output reads 0 while reset is held
    always_comb begin
        in_ready = (state == IDLE) && !rst;
        req_q    = (state == BUSY);
    end

    always_comb begin
        be_st    = 4'hF;
        wdata_st = store_data;
        case (funct3[1:0])
            2'b00: begin be_st = 4'b0001 << a_in; wdata_st = {4{store_data[7:0]}};  end
            2'b01: begin be_st = 4'b0011 << a_in; wdata_st = {2{store_data[15:0]}}; end
            default: ;
        endcase
    end

    always_comb begin
        rshift = dmem.dmem_rdata >> {cap_alu[1:0], 3'b000};
        half   = cap_alu[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
        case (cap_f3)
            3'b000:  fmt = {{24{rshift[7]}}, rshift[7:0]};
            3'b100:  fmt = {24'h0, rshift[7:0]};
            3'b001:  fmt = {{16{half[15]}}, half};
            3'b101:  fmt = {16'h0, half};
            default: fmt = dmem.dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            cap_alu <= '0; cap_rd <= '0; cap_f3 <= '0; cap_load <= 1'b0; cap_wb <= 1'b0;
            we_q <= 1'b0; addr_q <= '0; wdata_q <= '0; be_q <= '0;
        end else begin
            cnt <= (state == BUSY && !dmem.dmem_ready && !timeout_hit) ? cnt + 1'b1 : '0;
            if (start_ok) begin
                cap_alu  <= alu_or_ia4_in;
                cap_rd   <= rd_in;
                cap_f3   <= funct3;
                cap_load <= is_load_in;
                cap_wb   <= wb_enable_in;
                we_q     <= is_store && !is_load_in;
                addr_q   <= {alu_or_ia4_in[31:2], 2'b00};
                be_q     <= (is_store && !is_load_in) ? be_st : 4'hF;
                wdata_q  <= (is_store && !is_load_in) ? wdata_st : 32'h0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_enable <= 1'b0; alu_or_ia4 <= '0; data <= '0; is_load <= 1'b0; rd <= '0;
            misalign_err <= 1'b0; bus_err <= 1'b0;
        end else if (state == IDLE) begin
            misalign_err <= start_bad;
            bus_err      <= 1'b0;
            if (in_valid && !is_mem) begin
                wb_enable  <= wb_enable_in;
                alu_or_ia4 <= alu_or_ia4_in;
                data       <= 32'h0;
                is_load    <= 1'b0;
                rd         <= rd_in;
            end else begin
                wb_enable  <= 1'b0;
            end
        end else begin
            misalign_err <= 1'b0;
            bus_err      <= timeout_hit;
            if (done) begin
                wb_enable  <= cap_load && cap_wb;
                alu_or_ia4 <= cap_alu;
                data       <= cap_load ? fmt : 32'h0;
                is_load    <= cap_load;
                rd         <= cap_rd;
            end else begin
                wb_enable  <= 1'b0;
            end
        end
    end

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;
    assign dmem.dmem_be    = be_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, wb_enable_in, is_load_in, is_store;
    logic [31:0] alu_or_ia4_in, store_data;
    logic [2:0]  funct3;
    logic [4:0]  rd_in;
    logic        wb_enable, is_load, misalign_err, bus_err;
    logic [31:0] alu_or_ia4, data;
    logic [4:0]  rd;

    mem_stage_if bus();

    mem_stage #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .wb_enable_in(wb_enable_in), .alu_or_ia4_in(alu_or_ia4_in), .store_data(store_data),
        .is_load_in(is_load_in), .is_store(is_store), .funct3(funct3), .rd_in(rd_in),
        .dmem(bus), .wb_enable(wb_enable), .alu_or_ia4(alu_or_ia4), .data(data),
        .is_load(is_load), .rd(rd), .misalign_err(misalign_err), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ld, st;
        logic [2:0]  f3;
        logic [31:0] addr, sdata, rdata;
        int          wait_n;
        logic [4:0]  rdn;
        logic [3:0]  be;
        logic [31:0] wdata, dexp;
        logic        mis;
    } vec_t;

    typedef struct {
        logic        mis, berr, wb;
        logic [31:0] data, alu;
        logic [4:0]  rdn;
        logic        ld;
    } exp_t;

    exp_t sb[$];
    int tests = 0;
    int fails = 0;
    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0 && (wb_enable === 1'b1 || misalign_err === 1'b1 || bus_err === 1'b1)) begin
            if (sb.size() == 0) begin
                chk("unexpected_wb_event", {29'h0, wb_enable, misalign_err, bus_err}, 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("misalign_err", {31'h0, misalign_err}, {31'h0, e.mis});
                chk("bus_err", {31'h0, bus_err}, {31'h0, e.berr});
                chk("wb_enable", {31'h0, wb_enable}, {31'h0, e.wb});
                if (e.wb) begin
                    chk("data", data, e.data);
                    chk("alu_or_ia4", alu_or_ia4, e.alu);
                    chk("rd", {27'h0, rd}, {27'h0, e.rdn});
                    chk("is_load", {31'h0, is_load}, {31'h0, e.ld});
                end
            end
        end
    end

    task automatic drive(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sd, input logic [4:0] r);
        in_valid = 1'b1; wb_enable_in = 1'b1; is_load_in = ld; is_store = st;
        funct3 = f3; alu_or_ia4_in = addr; store_data = sd; rd_in = r;
    endtask

    task automatic run_vec(input vec_t v);
        logic mem, st_only;
        int busy;
        exp_t e;
        mem = v.ld | v.st;
        st_only = v.st & ~v.ld;
        busy = 0;
        @(negedge clk);
        chk("in_ready_idle", {31'h0, in_ready}, 32'h1);
        drive(v.ld, v.st, v.f3, v.addr, v.sdata, v.rdn);
        if (!mem || v.mis) begin
            e = '{v.mis, 1'b0, !v.mis, 32'h0, v.addr, v.rdn, 1'b0};
            sb.push_back(e);
        end else if (!st_only) begin
            e = '{1'b0, 1'b0, 1'b1, v.dexp, v.addr, v.rdn, 1'b1};
            sb.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0; is_load_in = 1'b0; is_store = 1'b0;
        if (!mem || v.mis) begin
            chk("no_req", {31'h0, bus.dmem_req}, 32'h0);
            chk("in_ready_stays", {31'h0, in_ready}, 32'h1);
            return;
        end
        for (int i = 0; i <= v.wait_n; i++) begin
            if (i == v.wait_n) begin
                bus.dmem_ready = 1'b1;
                bus.dmem_rdata = v.rdata;
                chk("dmem_addr", bus.dmem_addr, v.addr & 32'hFFFF_FFFC);
                chk("dmem_we", {31'h0, bus.dmem_we}, {31'h0, st_only});
                chk("dmem_be", {28'h0, bus.dmem_be}, {28'h0, v.be});
                if (st_only) chk("dmem_wdata", bus.dmem_wdata, v.wdata);
            end
            chk("req_held", {31'h0, bus.dmem_req}, 32'h1);
            if (!in_ready) busy++;
            @(negedge clk);
        end
        bus.dmem_ready = 1'b0;
        bus.dmem_rdata = 32'h0;
        chk("busy_cycles", 32'(busy), 32'(v.wait_n + 1));
        chk("in_ready_back", {31'h0, in_ready}, 32'h1);
        chk("req_drop", {31'h0, bus.dmem_req}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        exp_t e;
        //            ld st f3      addr          sdata         rdata         wait rd  be       wdata         dexp          mis
        vecs[0]  = '{1, 0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 3, 5'd5,  4'hF,    32'h0,        32'hDEADBEEF, 0};
        vecs[1]  = '{1, 0, 3'b000, 32'h103, 32'h0,        32'h80112233, 1, 5'd6,  4'hF,    32'h0,        32'hFFFFFF80, 0};
        vecs[2]  = '{1, 0, 3'b100, 32'h103, 32'h0,        32'h80112233, 0, 5'd7,  4'hF,    32'h0,        32'h00000080, 0};
        vecs[3]  = '{1, 0, 3'b101, 32'h102, 32'h0,        32'h80112233, 2, 5'd8,  4'hF,    32'h0,        32'h00008011, 0};
        vecs[4]  = '{1, 0, 3'b001, 32'h100, 32'h0,        32'h1234F00D, 1, 5'd9,  4'hF,    32'h0,        32'hFFFFF00D, 0};
        vecs[5]  = '{0, 1, 3'b000, 32'h21,  32'h000000AB, 32'h0,        1, 5'd10, 4'b0010, 32'hABABABAB, 32'h0,        0};
        vecs[6]  = '{0, 1, 3'b001, 32'h22,  32'h0000BEEF, 32'h0,        0, 5'd11, 4'b1100, 32'hBEEFBEEF, 32'h0,        0};
        vecs[7]  = '{0, 1, 3'b010, 32'h40,  32'h11223344, 32'h0,        2, 5'd12, 4'hF,    32'h11223344, 32'h0,        0};
        vecs[8]  = '{1, 0, 3'b010, 32'h102, 32'h0,        32'h0,        0, 5'd13, 4'hF,    32'h0,        32'h0,        1};
        vecs[9]  = '{1, 0, 3'b001, 32'h101, 32'h0,        32'h0,        0, 5'd14, 4'hF,    32'h0,        32'h0,        1};
        vecs[10] = '{1, 0, 3'b011, 32'h100, 32'h0,        32'h0,        0, 5'd15, 4'hF,    32'h0,        32'h0,        1};
        vecs[11] = '{0, 0, 3'b000, 32'hCAFEF00D, 32'h0,   32'h0,        0, 5'd7,  4'hF,    32'h0,        32'h0,        0};
        vecs[12] = '{1, 1, 3'b000, 32'h101, 32'h0,        32'h00007F00, 1, 5'd9,  4'hF,    32'h0,        32'h0000007F, 0};

        rst = 1'b1; in_valid = 1'b0; wb_enable_in = 1'b0; is_load_in = 1'b0; is_store = 1'b0;
        funct3 = 3'b000; alu_or_ia4_in = 32'h0; store_data = 32'h0; rd_in = 5'd0;
        bus.dmem_ready = 1'b0; bus.dmem_rdata = 32'h0;
        #1;
        chk("rst_req", {31'h0, bus.dmem_req}, 32'h0);
        chk("rst_outs", {wb_enable, is_load, misalign_err, bus_err, rd}, 32'h0);
        chk("rst_data", data, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // dmem_ready while idle must not produce anything
        @(negedge clk);
        bus.dmem_ready = 1'b1; bus.dmem_rdata = 32'h12345678;
        @(negedge clk);
        bus.dmem_ready = 1'b0;
        chk("idle_ready_no_req", {31'h0, bus.dmem_req}, 32'h0);
        chk("idle_ready_in_ready", {31'h0, in_ready}, 32'h1);

        // hung bus: request must drop after 16 cycles with a bus_err pulse
        @(negedge clk);
        drive(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 5'd3);
        e = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0};
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0; is_load_in = 1'b0;
        n = 0;
        while (bus.dmem_req === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("timeout_req_cycles", 32'(n), 32'd16);
        chk("timeout_bus_err", {31'h0, bus_err}, 32'h1);
        chk("timeout_in_ready", {31'h0, in_ready}, 32'h1);
        @(negedge clk);
        chk("bus_err_pulse", {31'h0, bus_err}, 32'h0);

        // reset in the middle of a pending load
        run_vec(vecs[12]);
        @(negedge clk);
        drive(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 5'd4);
        @(negedge clk);
        in_valid = 1'b0; is_load_in = 1'b0;
        @(negedge clk);
        chk("busy_before_rst", {31'h0, bus.dmem_req}, 32'h1);
        rst = 1'b1;
        #1;
        chk("midrst_req", {31'h0, bus.dmem_req}, 32'h0);
        chk("midrst_outs", {wb_enable, is_load, misalign_err, bus_err, rd}, 32'h0);
        chk("midrst_data", data, 32'h0);
        chk("midrst_alu", alu_or_ia4, 32'h0);
        chk("midrst_in_ready", {31'h0, in_ready}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        run_vec(vecs[0]);

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
